// File: rtl/flash_boot_record_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : flash_boot_record_ctrl
// Description : CPLD-side owner of the parallel CFI (Intel command set) flash
//               while the PFL is off the bus. Reads the boot-page record that
//               selects the PFL fpga_pgm page, and on request rewrites it
//               (clear status, unlock, block erase, word program, status poll).
// Ports       : clk_i/sys_reset_i      clock, async active-high reset
//               req_i/op_i/wr_page_i   operation request (0 read, 1 write)
//               busy_o/done_o/err_o    handshake and completion status
//               rd_page_o/rd_valid_o   result of the last record read (held)
//               flash_*                flash bus (strobes active low)
// Revision    : 1.0 - initial release
//==============================================================================
module flash_boot_record_ctrl #(
  parameter logic [24:0] RECORD_ADDR  = 25'h1FF0000,
  parameter logic [7:0]  SIG          = 8'hA5,
  parameter logic [1:0]  DEFAULT_PAGE = 2'b00,
  parameter int          T_WP         = 6,
  parameter int          T_ACC        = 8,
  parameter logic [23:0] POLL_LIMIT   = 24'hFFFFFF
) (
  input  logic        clk_i,
  input  logic        sys_reset_i,
  input  logic        req_i,
  input  logic        op_i,
  input  logic [1:0]  wr_page_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  rd_page_o,
  output logic        rd_valid_o,
  output logic [24:0] flash_addr_o,
  output logic [15:0] flash_dq_out_o,
  output logic        flash_dq_oe_o,
  input  logic [15:0] flash_dq_in_i,
  output logic        flash_cen_o,
  output logic        flash_oen_o,
  output logic        flash_wen_o,
  output logic        flash_advn_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ARR, S_RD_DATA, S_CLR_SR, S_UNLK1, S_UNLK2, S_ERS1, S_ERS2,
    S_ERS_POLL, S_PRG1, S_PRG2, S_PRG_POLL, S_ERR_CLR, S_RESTORE, S_FINISH
  } state_e;

  // Bus-cycle phases: SETUP/WP/HOLD make up a write, ACC/REC a read.
  typedef enum logic [2:0] {P_SETUP, P_WP, P_HOLD, P_ACC, P_REC} phase_e;

  localparam int                CNT_MAX   = (T_WP > T_ACC) ? T_WP : T_ACC;
  localparam int                CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  WP_LAST   = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0]  ACC_LAST  = CNT_W'(T_ACC - 1);
  localparam logic [23:0]       POLL_LAST = POLL_LIMIT - 24'd1;

  function automatic logic is_read(input state_e s);
    return (s == S_RD_DATA) || (s == S_ERS_POLL) || (s == S_PRG_POLL);
  endfunction

  function automatic logic is_write(input state_e s);
    return (s == S_RD_ARR) || (s == S_CLR_SR) || (s == S_UNLK1) || (s == S_UNLK2) ||
           (s == S_ERS1) || (s == S_ERS2) || (s == S_PRG1) || (s == S_PRG2) ||
           (s == S_ERR_CLR) || (s == S_RESTORE);
  endfunction

  function automatic logic [15:0] cmd_word(input state_e s, input logic [1:0] page);
    logic [15:0] w;
    case (s)
      S_RD_ARR, S_RESTORE: w = 16'h00FF;
      S_CLR_SR, S_ERR_CLR: w = 16'h0050;
      S_UNLK1:             w = 16'h0060;
      S_UNLK2, S_ERS2:     w = 16'h00D0;
      S_ERS1:              w = 16'h0020;
      S_PRG1:              w = 16'h0040;
      S_PRG2:              w = {SIG, 6'b000000, page};
      default:             w = 16'h0000;
    endcase
    return w;
  endfunction

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       poll_cnt_q, poll_cnt_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        page_q, page_d;
  logic              err_pend_q, err_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        rd_page_q, rd_page_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cen_q, cen_d;
  logic              oen_q, oen_d;
  logic              wen_q, wen_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              cyc_end;
  logic              restart_rd;
  logic              rec_valid;
  logic              sr_err;

  assign rec_valid = (data_q[15:8] == SIG) && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'b11);
  assign sr_err    = data_q[5] | data_q[4] | data_q[3] | data_q[1];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    data_d     = data_q;
    page_d     = page_q;
    err_pend_d = err_pend_q;
    err_d      = err_q;
    rd_page_d  = rd_page_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    cyc_end    = 1'b0;
    restart_rd = 1'b0;

    // Bus-cycle engine; cyc_end marks the last clock of the current cycle.
    if (state_q != S_IDLE && state_q != S_FINISH) begin
      case (phase_q)
        P_SETUP: begin
          phase_d = P_WP;
          cnt_d   = '0;
        end
        P_WP: begin
          if (cnt_q == WP_LAST) phase_d = P_HOLD;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end
        P_ACC: begin
          if (cnt_q == ACC_LAST) begin
            phase_d = P_REC;
            data_d  = flash_dq_in_i;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cyc_end = 1'b1;   // P_HOLD, P_REC
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          err_d      = 1'b0;
          err_pend_d = 1'b0;
          if (!op_i) begin
            state_d = S_RD_ARR;
          end else if (wr_page_i == 2'b11) begin
            state_d    = S_FINISH;
            err_pend_d = 1'b1;
          end else begin
            page_d  = wr_page_i;
            state_d = S_CLR_SR;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        err_d   = err_pend_q;
      end
      default: begin
        if (cyc_end) begin
          case (state_q)
            S_RD_ARR:  state_d = S_RD_DATA;
            S_RD_DATA: begin
              rd_page_d  = rec_valid ? data_q[1:0] : DEFAULT_PAGE;
              rd_valid_d = rec_valid;
              state_d    = S_FINISH;
            end
            S_CLR_SR:  state_d = S_UNLK1;
            S_UNLK1:   state_d = S_UNLK2;
            S_UNLK2:   state_d = S_ERS1;
            S_ERS1:    state_d = S_ERS2;
            S_ERS2:    state_d = S_ERS_POLL;
            S_PRG1:    state_d = S_PRG2;
            S_PRG2:    state_d = S_PRG_POLL;
            S_ERR_CLR: state_d = S_RESTORE;
            S_RESTORE: state_d = S_FINISH;
            S_ERS_POLL, S_PRG_POLL: begin
              if (data_q[7]) begin
                if (sr_err) begin
                  state_d    = S_ERR_CLR;
                  err_pend_d = 1'b1;
                end else begin
                  state_d = (state_q == S_ERS_POLL) ? S_PRG1 : S_RESTORE;
                end
              end else if (poll_cnt_q == POLL_LAST) begin
                state_d    = S_ERR_CLR;
                err_pend_d = 1'b1;
              end else begin
                poll_cnt_d = poll_cnt_q + 24'd1;
                restart_rd = 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // Every state change starts a fresh bus cycle and clears the poll count.
    if (state_d != state_q) begin
      phase_d    = is_read(state_d) ? P_ACC : P_SETUP;
      cnt_d      = '0;
      poll_cnt_d = '0;
    end else if (restart_rd) begin
      phase_d = P_ACC;
      cnt_d   = '0;
    end

    // Flash strobes are decoded from the next state so they leave flops.
    cen_d    = 1'b1;
    oen_d    = 1'b1;
    wen_d    = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = 16'h0000;
    if (is_write(state_d)) begin
      cen_d    = 1'b0;
      dq_oe_d  = 1'b1;
      dq_out_d = cmd_word(state_d, page_d);
      wen_d    = (phase_d != P_WP);
    end else if (is_read(state_d) && phase_d == P_ACC) begin
      cen_d = 1'b0;
      oen_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      state_q    <= S_IDLE;
      phase_q    <= P_SETUP;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      data_q     <= 16'h0000;
      page_q     <= 2'b00;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_page_q  <= DEFAULT_PAGE;
      rd_valid_q <= 1'b0;
      cen_q      <= 1'b1;
      oen_q      <= 1'b1;
      wen_q      <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      data_q     <= data_d;
      page_q     <= page_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_page_q  <= rd_page_d;
      rd_valid_q <= rd_valid_d;
      cen_q      <= cen_d;
      oen_q      <= oen_d;
      wen_q      <= wen_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rd_page_o      = rd_page_q;
  assign rd_valid_o     = rd_valid_q;
  assign flash_addr_o   = RECORD_ADDR;
  assign flash_dq_out_o = dq_out_q;
  assign flash_dq_oe_o  = dq_oe_q;
  assign flash_cen_o    = cen_q;
  assign flash_oen_o    = oen_q;
  assign flash_wen_o    = wen_q;
  assign flash_advn_o   = 1'b0;

endmodule
`default_nettype wire
